// File: rtl/instr_encoder_mem.sv
// instr_encoder_mem: packs decoded instruction fields into 32-bit words and
// stores them sequentially in a DEPTH-entry instruction memory. The memory has
// a registered fetch read port that works independently of the write side.
// Build option: define INSTR_ENC_WRAP_EN for ring mode. In ring mode the
// memory never stalls and full becomes a sticky "has wrapped" flag.
module instr_encoder_mem #(
  parameter int DEPTH = 64,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [4:0]       rdst2,
  input  logic [4:0]       rdst1,
  input  logic [4:0]       rsrc2,
  input  logic [4:0]       rsrc1,
  input  logic [15:0]      imm,
  input  logic [7:0]       src_addr,
  input  logic [7:0]       dst_addr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             illegal,
  input  logic [PTR_W-1:0] fetch_addr,
  output logic [31:0]      fetch_data
);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  localparam logic [PTR_W-1:0] LAST_ENTRY = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   MAX_COUNT  = (PTR_W + 1)'(DEPTH);

  logic [0:0]  state;
  logic [31:0] mem [DEPTH];
  logic [31:0] word;
  logic        legal;
  logic        xfer;
  logic        wr_en;
  logic        last;

  assign legal    = (opcode <= 6'h10);
  assign in_ready = (state == ST_LOAD);
  // clear wins over a same-cycle handshake, so that transfer is dropped
  assign xfer     = in_valid && in_ready && !clear;
  assign wr_en    = xfer && legal;
  assign last     = (wr_ptr == LAST_ENTRY);

  // Pack the field set into a word according to the opcode format
  always_comb begin
    word        = '0;
    word[31:26] = opcode;
    case (opcode)
      6'h00: begin
        word[25:21] = rdst2;
        word[15:0]  = imm;
      end
      6'h01: begin
        word[25:21] = rdst2;
        word[4:0]   = rsrc2;
      end
      6'h02: begin
        word[25:21] = rdst2;
        word[7:0]   = src_addr;
      end
      6'h03: begin
        word[25:18] = dst_addr;
        word[4:0]   = rsrc2;
      end
      default: begin
        // R-type layout; illegal opcodes also land here but are never written
        word[25:21] = rdst2;
        word[20:16] = rdst1;
        word[9:5]   = rsrc2;
        word[4:0]   = rsrc1;
      end
    endcase
  end

  // Write pointer, occupancy, state and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_LOAD;
      wr_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      illegal <= 1'b0;
    end else if (clear) begin
      state   <= ST_LOAD;
      wr_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      illegal <= 1'b0;
    end else if (xfer) begin
      if (!legal) begin
        illegal <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count != MAX_COUNT) begin
          count <= count + 1'b1;
        end
        if (last) begin
          full <= 1'b1;
`ifdef INSTR_ENC_WRAP_EN
          state <= ST_LOAD;
`else
          state <= ST_FULL;
`endif
        end
      end
    end
  end

  // Instruction memory write port (contents survive reset and clear)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= word;
    end
  end

  // Registered fetch read; a same-address write returns the old word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_data <= '0;
    end else begin
      fetch_data <= mem[fetch_addr];
    end
  end

endmodule

// File: tb/tb_instr_encoder_mem.sv
// tb_instr_encoder_mem: directed vectors with hand-computed words for
// instr_encoder_mem. Stall or ring behaviour follows INSTR_ENC_WRAP_EN.
`timescale 1ns/1ps
module tb_instr_encoder_mem;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_ready;
  logic [5:0]  opcode;
  logic [4:0]  rdst2, rdst1, rsrc2, rsrc1;
  logic [15:0] imm;
  logic [7:0]  src_addr, dst_addr;
  logic [5:0]  wr_ptr;
  logic [6:0]  count;
  logic        full, illegal;
  logic [5:0]  fetch_addr;
  logic [31:0] fetch_data;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] d;
  logic [31:0] exp0;

  instr_encoder_mem #(.DEPTH(64)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rdst2(rdst2), .rdst1(rdst1), .rsrc2(rsrc2), .rsrc1(rsrc1),
    .imm(imm), .src_addr(src_addr), .dst_addr(dst_addr),
    .wr_ptr(wr_ptr), .count(count), .full(full), .illegal(illegal),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present one field set for a single cycle; returns #1 after the edge
  task automatic push(input logic [5:0] op, input logic [4:0] d2, input logic [4:0] d1,
                      input logic [4:0] s2, input logic [4:0] s1, input logic [15:0] im,
                      input logic [7:0] sa, input logic [7:0] da);
    opcode = op; rdst2 = d2; rdst1 = d1; rsrc2 = s2; rsrc1 = s1;
    imm = im; src_addr = sa; dst_addr = da;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] data);
    fetch_addr = a;
    @(posedge clk); #1;
    data = fetch_data;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  // MOV word used to fill the memory: rdst2 = i mod 32, rsrc2 = 31 - (i mod 32)
  function automatic logic [31:0] fill_word(input int unsigned i);
    logic [4:0] r;
    r = 5'(i % 32);
    return {6'h01, r, 16'h0000, 5'd31 - r};
  endfunction

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; fetch_addr = '0;
    opcode = '0; rdst2 = '0; rdst1 = '0; rsrc2 = '0; rsrc1 = '0;
    imm = '0; src_addr = '0; dst_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_fetch_data", fetch_data, 32'h0);

    // MOVI with unrelated fields set to all ones
    push(6'h00, 5'd3, 5'd31, 5'd31, 5'd31, 16'hBEEF, 8'hFF, 8'hFF);
    chk("movi_wr_ptr", 32'(wr_ptr), 32'd1);
    chk("movi_count", 32'(count), 32'd1);
    rd(6'd0, d);
    chk("movi_word", d, 32'h0060BEEF);

    // Fill all 64 entries back to back
    pulse_clear();
    for (int unsigned i = 0; i < 64; i++) begin
      push(6'h01, 5'(i % 32), 5'(i), 5'd31 - 5'(i % 32), 5'(~i), 16'hA5A5, 8'h5A, 8'hC3);
      if (i == 62) begin
        chk("fill63_full", 32'(full), 32'd0);
        chk("fill63_in_ready", 32'(in_ready), 32'd1);
      end
    end
    chk("fill64_full", 32'(full), 32'd1);
    chk("fill64_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("fill64_count", 32'(count), 32'd64);
`ifdef INSTR_ENC_WRAP_EN
    chk("fill64_in_ready", 32'(in_ready), 32'd1);
    push(6'h00, 5'd1, 5'd0, 5'd0, 5'd0, 16'h1234, 8'h00, 8'h00);
    push(6'h00, 5'd2, 5'd0, 5'd0, 5'd0, 16'h5678, 8'h00, 8'h00);
    chk("wrap_wr_ptr", 32'(wr_ptr), 32'd2);
    chk("wrap_count", 32'(count), 32'd64);
    chk("wrap_full", 32'(full), 32'd1);
    chk("wrap_in_ready", 32'(in_ready), 32'd1);
    rd(6'd1, d);
    chk("wrap_mem1", d, 32'h00405678);
    exp0 = 32'h00201234;
`else
    chk("fill64_in_ready", 32'(in_ready), 32'd0);
    // A 65th offer is held off for two cycles
    opcode = 6'h00; rdst2 = 5'd1; imm = 16'h1234;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("stall_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("stall_count", 32'(count), 32'd64);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    exp0 = fill_word(0);
`endif
    rd(6'd0, d);
    chk("mem0_after_fill", d, exp0);
    rd(6'd63, d);
    chk("mem63_after_fill", d, fill_word(63));

    // clear together with a valid offer: restart, nothing written
    opcode = 6'h00; rdst2 = 5'd7; imm = 16'hDEAD;
    in_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    chk("clrv_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("clrv_count", 32'(count), 32'd0);
    chk("clrv_full", 32'(full), 32'd0);
    chk("clrv_in_ready", 32'(in_ready), 32'd1);
    rd(6'd0, d);
    chk("clrv_mem0", d, exp0);

    // STORE, R-type, and the MOV that seeds entry 2
    push(6'h03, 5'd31, 5'd31, 5'd7, 5'd31, 16'hFFFF, 8'hFF, 8'hA5);
    push(6'h04, 5'd1, 5'd2, 5'd3, 5'd4, 16'hFFFF, 8'hFF, 8'hFF);
    push(6'h01, 5'd0, 5'd9, 5'd1, 5'd9, 16'hFFFF, 8'hFF, 8'hFF);
    rd(6'd0, d);
    chk("store_word", d, 32'h0E940007);
    rd(6'd1, d);
    chk("rtype_word", d, 32'h10220064);
    rd(6'd2, d);
    chk("mov_word", d, 32'h04000001);

    // Write and fetch entry 2 in the same cycle
    pulse_clear();
    push(6'h03, 5'd31, 5'd31, 5'd7, 5'd31, 16'hFFFF, 8'hFF, 8'hA5);
    push(6'h04, 5'd1, 5'd2, 5'd3, 5'd4, 16'hFFFF, 8'hFF, 8'hFF);
    fetch_addr = 6'd2;
    push(6'h01, 5'd1, 5'd0, 5'd0, 5'd0, 16'h0000, 8'h00, 8'h00);
    chk("rbw_old", fetch_data, 32'h04000001);
    @(posedge clk); #1;
    chk("rbw_new", fetch_data, 32'h04200000);

    // LOAD, MOV, then an illegal opcode at wr_ptr 5
    push(6'h02, 5'd5, 5'd31, 5'd31, 5'd31, 16'hFFFF, 8'h3C, 8'hFF);
    push(6'h01, 5'd3, 5'd0, 5'd9, 5'd0, 16'h0000, 8'h00, 8'h00);
    chk("pre_ill_wr_ptr", 32'(wr_ptr), 32'd5);
    push(6'h2A, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1111, 8'h11, 8'h11);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_wr_ptr", 32'(wr_ptr), 32'd5);
    chk("ill_count", 32'(count), 32'd5);
    chk("ill_in_ready", 32'(in_ready), 32'd1);
    rd(6'd3, d);
    chk("load_word", d, 32'h08A0003C);
    rd(6'd4, d);
    chk("mov2_word", d, 32'h04600009);
    rd(6'd5, d);
    chk("ill_mem5", d, fill_word(5));
    pulse_clear();
    chk("clr_illegal", 32'(illegal), 32'd0);
    chk("clr_wr_ptr", 32'(wr_ptr), 32'd0);

    // Opcode boundary: 0x10 is legal R-type, 0x11 is illegal
    push(6'h10, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 8'hFF, 8'hFF);
    chk("op10_illegal", 32'(illegal), 32'd0);
    chk("op10_wr_ptr", 32'(wr_ptr), 32'd1);
    push(6'h11, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 8'h00, 8'h00);
    chk("op11_illegal", 32'(illegal), 32'd1);
    chk("op11_wr_ptr", 32'(wr_ptr), 32'd1);
    rd(6'd0, d);
    chk("op10_word", d, 32'h43FF03FF);
    rd(6'd1, d);
    chk("op11_mem1", d, 32'h10220064);

    // Asynchronous reset in the middle of a load
    push(6'h01, 5'd4, 5'd0, 5'd4, 5'd0, 16'h0000, 8'h00, 8'h00);
    in_valid = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_illegal", 32'(illegal), 32'd0);
    chk("arst_fetch_data", fetch_data, 32'h0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
